// File: rtl/multiplicador.sv
// rtl/multiplicador.sv - sequential 16x16 unsigned shift-and-add multiplier
module multiplicador (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        St,
    input  logic [15:0] Multiplicador,
    input  logic [15:0] Multiplicando,
    output logic        Idle,
    output logic        Done,
    output logic [31:0] Produto
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ADD   = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]  state;
    logic [32:0] acc;
    logic [15:0] mcand;
    logic [3:0]  cnt;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
            acc   <= '0;
            mcand <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (St) begin
                        acc   <= {17'b0, Multiplicador};
                        mcand <= Multiplicando;
                        cnt   <= '0;
                        state <= S_ADD;
                    end
                end
                S_ADD: begin
                    // bit 32 of acc captures the carry out of the upper-half sum
                    if (acc[0])
                        acc[32:16] <= {1'b0, acc[31:16]} + {1'b0, mcand};
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    acc <= {1'b0, acc[32:1]};
                    if (cnt == 4'd15) begin
                        state <= S_DONE;
                    end else begin
                        cnt   <= cnt + 4'd1;
                        state <= S_ADD;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign Idle    = (state == S_IDLE);
    assign Done    = (state == S_DONE);
    assign Produto = acc[31:0];

endmodule

// File: tb/tb_multiplicador.sv
// tb/tb_multiplicador.sv - self-checking bench for multiplicador
module tb_multiplicador;

    logic        Clk;
    logic        Reset;
    logic        St;
    logic [15:0] Multiplicador;
    logic [15:0] Multiplicando;
    logic        Idle;
    logic        Done;
    logic [31:0] Produto;

    int passed = 0;
    int total  = 0;

    multiplicador dut (
        .Clk(Clk),
        .Reset(Reset),
        .St(St),
        .Multiplicador(Multiplicador),
        .Multiplicando(Multiplicando),
        .Idle(Idle),
        .Done(Done),
        .Produto(Produto)
    );

    initial Clk = 1'b0;
    always #20 Clk = ~Clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference: product by plain arithmetic; Done expected exactly 32 negedges after the start edge.
    task automatic do_mul(input logic [15:0] a, input logic [15:0] b, input int nst, input int glitch);
        logic [31:0] exp;
        logic [31:0] at_done;
        int          ndone;
        int          when;
        exp   = 32'(a) * 32'(b);
        ndone = 0;
        when  = -1;
        at_done = '0;
        Multiplicador = a;
        Multiplicando = b;
        St = 1'b1;
        @(posedge Clk);
        for (int k = 0; k < 36; k++) begin
            @(negedge Clk);
            if (Done) begin
                ndone++;
                when    = k;
                at_done = Produto;
            end
            St = (k < nst - 1) || (k == glitch);
            Multiplicador = 16'($urandom);
            Multiplicando = 16'($urandom);
        end
        St = 1'b0;
        chk("done_count", 32'(ndone), 32'd1);
        chk("done_latency", 32'(when), 32'd32);
        chk("product", at_done, exp);
        chk("idle_after", {31'b0, Idle}, 32'd1);
        chk("product_held", Produto, exp);
    endtask

    vec_t vecs[3];

    initial begin
        int seen_done;
        vecs[0] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[1] = '{16'h8000, 16'h0002, 32'h00010000};
        vecs[2] = '{16'h1234, 16'h5678, 32'h06260060};

        Reset = 1'b0;
        St = 1'b0;
        Multiplicador = '0;
        Multiplicando = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge Clk);
            chk("rst_idle", {31'b0, Idle}, 32'd1);
            chk("rst_done", {31'b0, Done}, 32'd0);
            chk("rst_prod", Produto, 32'd0);
        end
        Reset = 1'b1;
        @(negedge Clk);
        chk("rel_idle", {31'b0, Idle}, 32'd1);
        chk("rel_done", {31'b0, Done}, 32'd0);
        chk("rel_prod", Produto, 32'd0);

        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                do_mul(16'(i), 16'(j), 2, -1);

        for (int v = 0; v < 3; v++) begin
            do_mul(vecs[v].a, vecs[v].b, 1, -1);
            chk("vec_table", Produto, vecs[v].p);
        end

        for (int r = 0; r < 20; r++)
            do_mul(16'($urandom), 16'($urandom), 1 + int'($urandom_range(0, 3)), -1);

        do_mul(16'd3, 16'd5, 1, 10);

        // Mid-operation reset: aborts with no Done, then a fresh op works.
        Multiplicador = 16'hFFFF;
        Multiplicando = 16'hFFFF;
        St = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        St = 1'b0;
        for (int k = 1; k <= 20; k++) @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("midrst_prod", Produto, 32'd0);
        chk("midrst_idle", {31'b0, Idle}, 32'd1);
        chk("midrst_done", {31'b0, Done}, 32'd0);
        seen_done = 0;
        @(negedge Clk);
        Reset = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            if (Done) seen_done++;
        end
        chk("midrst_no_done", 32'(seen_done), 32'd0);
        chk("midrst_prod_idle", Produto, 32'd0);
        do_mul(16'd7, 16'd6, 1, -1);
        chk("after_rst_42", Produto, 32'd42);

        do_mul(16'd9, 16'd9, 1, -1);
        for (int k = 0; k < 50; k++) begin
            @(negedge Clk);
            chk("hold_prod", Produto, 32'd81);
            chk("hold_idle", {31'b0, Idle}, 32'd1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
